// File: rtl/adder_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_subtractor_pkg
// Description : Shared constants, FSM states and the captured-vector record
//               for the adder/subtractor response checker.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_subtractor_pkg;

    localparam int c_WIDTH       = 4;
    localparam int c_NUM_VECTORS = 512;
    localparam int c_CNT_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic               sub;
        logic [c_WIDTH-1:0] a;
        logic [c_WIDTH-1:0] b;
        logic [c_WIDTH-1:0] result;
        logic               cout;
    } vec_t;

endpackage
`default_nettype wire

// File: rtl/adder_subtractor_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_subtractor_checker_if
// Description : Vector/response inputs and status outputs of the checker.
//               order_err exists only when CHECKER_ORDER_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_subtractor_checker_if
    import adder_subtractor_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CNT_W = c_CNT_W
);

    logic             start;
    logic             vec_valid;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic             vec_sub;
    logic [WIDTH-1:0] dut_result;
    logic             dut_cout;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] checked_count;
    logic [CNT_W-1:0] err_count;
    logic             fail_valid;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    logic             fail_sub;
    logic [WIDTH-1:0] fail_result;
    logic             fail_cout;
`ifdef CHECKER_ORDER_CHECK_EN
    logic             order_err;
`endif

    modport master (
        output start, vec_valid, vec_a, vec_b, vec_sub, dut_result, dut_cout,
        input  busy, done, pass, checked_count, err_count, fail_valid,
               fail_a, fail_b, fail_sub, fail_result, fail_cout
`ifdef CHECKER_ORDER_CHECK_EN
        , input order_err
`endif
    );

    modport slave (
        input  start, vec_valid, vec_a, vec_b, vec_sub, dut_result, dut_cout,
        output busy, done, pass, checked_count, err_count, fail_valid,
               fail_a, fail_b, fail_sub, fail_result, fail_cout
`ifdef CHECKER_ORDER_CHECK_EN
        , output order_err
`endif
    );

endinterface
`default_nettype wire

// File: rtl/adder_subtractor_golden.sv
`default_nettype none
// ============================================================================
// Module      : adder_subtractor_golden
// Description : Combinational reference sum/difference, computed in WIDTH+1
//               bits so the carry (no-borrow for subtraction) falls out on top.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_subtractor_golden #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_sub,
    output logic      [WIDTH-1:0] o_result,
    output logic                  o_cout
);

    logic [WIDTH:0] w_sum;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b ^ {WIDTH{i_sub}}} + {{WIDTH{1'b0}}, i_sub};
    assign o_result = w_sum[WIDTH-1:0];
    assign o_cout   = w_sum[WIDTH];

endmodule
`default_nettype wire

// File: rtl/adder_subtractor_checker.sv
`default_nettype none
// ============================================================================
// Module      : adder_subtractor_checker
// Description : Compares each applied vector's DUT response against a golden
//               model, counts vectors/mismatches and captures the first
//               failure. Optional sweep-order tracking: CHECKER_ORDER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_subtractor_checker
    import adder_subtractor_pkg::*;
#(
    parameter int WIDTH       = c_WIDTH,
    parameter int NUM_VECTORS = c_NUM_VECTORS,
    parameter int CNT_W       = c_CNT_W
) (
    input wire logic clk,
    input wire logic rst,
    adder_subtractor_checker_if.slave bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_checked;
    logic [CNT_W-1:0] w_checked_next;
    logic [CNT_W-1:0] w_checked_inc;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] w_err_next;
    vec_t             r_fail;
    vec_t             w_fail_next;
    logic             r_fail_valid;
    logic             w_fail_valid_next;
    logic             r_pass;
    logic             w_pass_next;
    logic [WIDTH-1:0] w_exp_result;
    logic             w_exp_cout;
    logic             w_mismatch;
    logic             w_clear;
    logic             w_accept;
    logic             w_order_hit;

    adder_subtractor_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .i_a      (bus.vec_a),
        .i_b      (bus.vec_b),
        .i_sub    (bus.vec_sub),
        .o_result (w_exp_result),
        .o_cout   (w_exp_cout)
    );

    assign w_mismatch    = (bus.dut_result != w_exp_result) || (bus.dut_cout != w_exp_cout);
    assign w_clear       = (r_state != ST_RUN) && bus.start;
    assign w_accept      = (r_state == ST_RUN) && bus.vec_valid;
    assign w_checked_inc = r_checked + CNT_W'(1);

`ifdef CHECKER_ORDER_CHECK_EN
    logic r_order_err;
    logic w_pos_err;

    // The sweep index itself is {sub, a, b}: sub outermost, then A, then B.
    assign w_pos_err   = (r_checked[2*WIDTH:0] != {bus.vec_sub, bus.vec_a, bus.vec_b});
    assign w_order_hit = r_order_err || w_pos_err;

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_order_err <= 1'b0;
        end else if (w_accept && w_pos_err) begin
            r_order_err <= 1'b1;
        end
    end

    assign bus.order_err = r_order_err;
`else
    assign w_order_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_checked_next    = r_checked;
        w_err_next        = r_err;
        w_fail_next       = r_fail;
        w_fail_valid_next = r_fail_valid;
        w_pass_next       = r_pass;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_next      = ST_RUN;
                    w_checked_next    = '0;
                    w_err_next        = '0;
                    w_fail_next       = '0;
                    w_fail_valid_next = 1'b0;
                    w_pass_next       = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.vec_valid) begin
                    w_checked_next = w_checked_inc;
                    if (w_mismatch) begin
                        if (r_err != '1) begin
                            w_err_next = r_err + CNT_W'(1);
                        end
                        if (!r_fail_valid) begin
                            w_fail_valid_next = 1'b1;
                            w_fail_next       = '{sub:    bus.vec_sub,
                                                  a:      bus.vec_a,
                                                  b:      bus.vec_b,
                                                  result: bus.dut_result,
                                                  cout:   bus.dut_cout};
                        end
                    end
                    // Last vector: its own mismatch must already be in the verdict.
                    if (w_checked_inc == CNT_W'(NUM_VECTORS)) begin
                        w_state_next = ST_DONE;
                        w_pass_next  = (w_err_next == '0) && !w_order_hit;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checked    <= '0;
            r_err        <= '0;
            r_fail       <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_checked    <= w_checked_next;
            r_err        <= w_err_next;
            r_fail       <= w_fail_next;
            r_fail_valid <= w_fail_valid_next;
            r_pass       <= w_pass_next;
        end
    end

    assign bus.busy          = (r_state == ST_RUN);
    assign bus.done          = (r_state == ST_DONE);
    assign bus.pass          = r_pass;
    assign bus.checked_count = r_checked;
    assign bus.err_count     = r_err;
    assign bus.fail_valid    = r_fail_valid;
    assign bus.fail_a        = r_fail.a;
    assign bus.fail_b        = r_fail.b;
    assign bus.fail_sub      = r_fail.sub;
    assign bus.fail_result   = r_fail.result;
    assign bus.fail_cout     = r_fail.cout;

endmodule
`default_nettype wire

// File: tb/tb_adder_subtractor_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_subtractor_checker
// Description : Self-checking bench for adder_subtractor_checker with an
//               arithmetic reference model and randomized sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_subtractor_checker;

    localparam int W  = 4;
    localparam int NV = 512;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_subtractor_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    adder_subtractor_checker #(
        .WIDTH       (W),
        .NUM_VECTORS (NV),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_run, m_done, m_fail_valid, m_order;
    int m_checked, m_err;
    int m_fa, m_fb, m_fs, m_fr, m_fc;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns {cout, result} from plain integer arithmetic.
    function automatic logic [4:0] golden(int a, int b, int sub);
        int r, c;
        if (sub == 0) begin
            r = (a + b) % 16;
            c = (a + b >= 16) ? 1 : 0;
        end else begin
            r = (a - b + 16) % 16;
            c = (a >= b) ? 1 : 0;
        end
        return {c[0], r[3:0]};
    endfunction

    task automatic model_clear();
        m_checked = 0; m_err = 0; m_fail_valid = 0; m_order = 0;
        m_fa = 0; m_fb = 0; m_fs = 0; m_fr = 0; m_fc = 0;
    endtask

    task automatic tick();
        logic [4:0] g;
        int pos;
        if (!m_run) begin
            if (bus.start) begin
                model_clear();
                m_run  = 1;
                m_done = 0;
            end
        end else if (bus.vec_valid) begin
            g   = golden(int'(bus.vec_a), int'(bus.vec_b), int'(bus.vec_sub));
            pos = int'(bus.vec_sub) * 256 + int'(bus.vec_a) * 16 + int'(bus.vec_b);
            if (pos != m_checked) m_order = 1;
            if (bus.dut_result != g[3:0] || bus.dut_cout != g[4]) begin
                if (m_err < 1023) m_err++;
                if (!m_fail_valid) begin
                    m_fail_valid = 1;
                    m_fa = int'(bus.vec_a); m_fb = int'(bus.vec_b); m_fs = int'(bus.vec_sub);
                    m_fr = int'(bus.dut_result); m_fc = int'(bus.dut_cout);
                end
            end
            m_checked++;
            if (m_checked == NV) begin
                m_run  = 0;
                m_done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_run = 0; m_done = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all(string tag);
        bit exp_pass;
        exp_pass = m_done && (m_err == 0);
`ifdef CHECKER_ORDER_CHECK_EN
        exp_pass = exp_pass && !m_order;
        chk({tag, ".order_err"}, 32'(bus.order_err), 32'(m_order));
`endif
        chk({tag, ".busy"},       32'(bus.busy),          32'(m_run));
        chk({tag, ".done"},       32'(bus.done),          32'(m_done));
        chk({tag, ".pass"},       32'(bus.pass),          32'(exp_pass));
        chk({tag, ".checked"},    32'(bus.checked_count), 32'(m_checked));
        chk({tag, ".err"},        32'(bus.err_count),     32'(m_err));
        chk({tag, ".fail_valid"}, 32'(bus.fail_valid),    32'(m_fail_valid));
        chk({tag, ".fail_a"},     32'(bus.fail_a),        32'(m_fa));
        chk({tag, ".fail_b"},     32'(bus.fail_b),        32'(m_fb));
        chk({tag, ".fail_sub"},   32'(bus.fail_sub),      32'(m_fs));
        chk({tag, ".fail_res"},   32'(bus.fail_result),   32'(m_fr));
        chk({tag, ".fail_cout"},  32'(bus.fail_cout),     32'(m_fc));
    endtask

    task automatic send_raw(int a, int b, int sub, int res, int cout);
        bus.vec_valid  = 1'b1;
        bus.vec_a      = W'(a);
        bus.vec_b      = W'(b);
        bus.vec_sub    = sub[0];
        bus.dut_result = W'(res);
        bus.dut_cout   = cout[0];
        tick();
        bus.vec_valid  = 1'b0;
    endtask

    // Applies a vector with the correct response, or a corrupted one when fault=1.
    task automatic send(int a, int b, int sub, bit fault);
        logic [4:0] g;
        g = golden(a, b, sub);
        if (fault) g = g ^ 5'($urandom_range(1, 31));
        send_raw(a, b, sub, int'(g[3:0]), int'(g[4]));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic idle_gap();
        if ($urandom_range(0, 7) == 0) tick();
    endtask

    task automatic full_sweep(string tag);
        for (int i = 0; i < NV; i++) begin
            send((i >> 4) & 15, i & 15, i >> 8, 1'b0);
            idle_gap();
        end
        check_all(tag);
    endtask

    initial begin
        bus.start = 1'b0; bus.vec_valid = 1'b0;
        bus.vec_a = '0; bus.vec_b = '0; bus.vec_sub = 1'b0;
        bus.dut_result = '0; bus.dut_cout = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        check_all("reset");

        // Correct in-order sweep, spot-checking the arithmetic corners.
        pulse_start();
        check_all("start1");
        for (int i = 0; i < NV; i++) begin
            send((i >> 4) & 15, i & 15, i >> 8, 1'b0);
            if (i == 241) check_all("corner_15p1");
            if (i == 309) check_all("corner_3m5");
            if (i == 339) check_all("corner_5m3");
            idle_gap();
        end
        check_all("sweep1");
        chk("sweep1.pass_const", 32'(bus.pass), 32'd1);
        chk("sweep1.count_const", 32'(bus.checked_count), 32'd512);

        // vec_valid in DONE is ignored, even when it carries a bad response.
        send(2, 2, 0, 1'b1);
        check_all("done_valid");

        // start in DONE clears and re-enters RUN; faults at #20 and #300.
        pulse_start();
        check_all("restart");
        for (int i = 0; i < NV; i++) begin
            if (i == 19) send_raw(1, 3, 0, 5, 0);
            else         send((i >> 4) & 15, i & 15, i >> 8, i == 299);
            if (i == 150) begin
                pulse_start();
                check_all("midrun_start");
            end
        end
        check_all("fault");
        chk("fault.err_const",    32'(bus.err_count),   32'd2);
        chk("fault.pass_const",   32'(bus.pass),        32'd0);
        chk("fault.fail_a_const", 32'(bus.fail_a),      32'd1);
        chk("fault.fail_b_const", 32'(bus.fail_b),      32'd3);
        chk("fault.fail_r_const", 32'(bus.fail_result), 32'd5);

        // Random vectors, random faults and gaps.
        pulse_start();
        for (int i = 0; i < NV; i++) begin
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                 $urandom_range(0, 15) == 0);
            if ((i % 128) == 127) check_all("random");
            idle_gap();
        end
        check_all("random_end");

        // Abort mid-sweep by reset, then IDLE behaviour and a clean sweep.
        pulse_start();
        for (int i = 0; i < 100; i++) send((i >> 4) & 15, i & 15, 0, 1'b1);
        do_reset();
        check_all("abort");
        send(7, 9, 1, 1'b1);
        check_all("idle_valid");
        bus.start = 1'b1;
        send(0, 0, 0, 1'b1);
        bus.start = 1'b0;
        check_all("start_with_valid");
        full_sweep("after_abort");

`ifdef CHECKER_ORDER_CHECK_EN
        // Vectors #0 and #1 swapped, responses correct.
        pulse_start();
        send(0, 1, 0, 1'b0);
        send(0, 0, 0, 1'b0);
        for (int i = 2; i < NV; i++) send((i >> 4) & 15, i & 15, i >> 8, 1'b0);
        check_all("order_swap");
        chk("order_swap.order_err_const", 32'(bus.order_err), 32'd1);
        chk("order_swap.pass_const",      32'(bus.pass),      32'd0);
        pulse_start();
        check_all("order_cleared");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_subtractor_checker.md
Name: adder_subtractor_checker

Overview:
- Response-side counterpart to the exhaustive adder/subtractor stimulus sweep. It receives each applied vector together with the DUT response, computes the golden sum/difference, and compares the two.
- Counts checked vectors and mismatches, captures the first failing vector, and reports done/pass once the full sweep has been consumed.
- Sits beside the adder/subtractor DUT in self-checking benches and in on-chip BIST wrappers.

Parameters:
- WIDTH, 4, operand and result width in bits.
- NUM_VECTORS, 512, vectors per sweep (2^(2*WIDTH) combinations x 2 values of subtract).
- CNT_W, 10, counter width; must satisfy 2^CNT_W > NUM_VECTORS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep.
- vec_valid  in  1  the vector and response on the inputs are valid this cycle.
- vec_a  in  WIDTH  applied operand A.
- vec_b  in  WIDTH  applied operand B.
- vec_sub  in  1  applied subtract control.
- dut_result  in  WIDTH  DUT Result.
- dut_cout  in  1  DUT Cout.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  valid when done is high; 1 means zero mismatches.
- checked_count  out  CNT_W  number of vectors consumed in the current sweep.
- err_count  out  CNT_W  number of mismatches; saturates at all-ones.
- fail_valid  out  1  a first failure has been captured.
- fail_a, fail_b  out  WIDTH  operands of the first failing vector.
- fail_sub  out  1  subtract value of the first failing vector.
- fail_result  out  WIDTH  DUT Result of the first failing vector.
- fail_cout  out  1  DUT Cout of the first failing vector.

Behaviour:
- Golden model, computed in WIDTH+1 bits: {exp_cout, exp_result} = vec_a + (vec_b XOR {WIDTH{vec_sub}}) + vec_sub.
  - For subtraction, Cout=1 means no borrow.
  - Mismatch = (dut_result != exp_result) OR (dut_cout != exp_cout).
- DUT is combinational. The response is sampled in the same cycle as vec_valid. Counters and capture registers update on that clock edge, so outputs reflect the vector one cycle later.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: clear checked_count, err_count, fail_* and fail_valid, then go to RUN.
  - RUN, vec_valid=1:
    - checked_count increments.
    - On mismatch, err_count increments, saturating at all-ones.
    - On the first mismatch only, fail_* are loaded and fail_valid is set.
  - RUN, leaving: when the incremented checked_count equals NUM_VECTORS, go to DONE on the same edge.
  - DONE: hold all counters. pass = (err_count == 0). start=1 clears everything and goes to RUN.
- vec_valid is ignored in IDLE and DONE. start is ignored in RUN; no restart mid-sweep.
- The final vector, if it mismatches, is counted and can be the captured failure in the same cycle that DONE is entered.
- Reset: state IDLE; busy=0, done=0, pass=0; all counters 0; fail_valid=0; all fail_* = 0. Reset mid-RUN aborts the sweep and discards its results.
- If start and vec_valid are both high in IDLE, start is taken and that vector is not counted.
- Combinational outputs: busy=(state==RUN), done=(state==DONE). pass is registered and is 0 whenever done=0.

Optional Feature:
- Macro: CHECKER_ORDER_CHECK_EN.
- Defined: the block also tracks the expected sweep position.
  - Expected order: vec_sub=0 first, then 1; within each, A is the outer loop and B the inner loop, each counting 0 to 2^WIDTH-1.
  - Adds a sticky output order_err (1 bit), set when an accepted vector's {vec_sub, vec_a, vec_b} differs from the expected position.
  - order_err forces pass=0. It clears on start and on reset.
- Not defined: no order_err port and no position tracking. Vectors in any order are accepted.

Decomposition:
- Package adder_subtractor_pkg holds:
  - WIDTH and NUM_VECTORS constants.
  - A state enum {IDLE, RUN, DONE}.
  - A vector struct {sub, a, b, result, cout} used for the fail_* capture register.
- One natural sub-module: adder_subtractor_golden, a combinational reference model producing exp_result and exp_cout.

Test Plan:
- Full correct sweep: start, then 512 vectors in order with correct responses -> done=1 after the 512th accepted vector, pass=1, checked_count=512, err_count=0, fail_valid=0.
- Arithmetic corners, all correct responses, none flagged:
  - A=15, B=1, sub=0 -> expected result 0, cout 1.
  - A=3, B=5, sub=1 -> expected result 14, cout 0.
  - A=5, B=3, sub=1 -> expected result 2, cout 1.
- Fault injection on vector #20 (A=1, B=3, sub=0) with dut_result=5 instead of 4 and cout=0, plus a second fault on vector #300 -> err_count=2, pass=0, fail_a=1, fail_b=3, fail_sub=0, fail_result=5, fail_cout=0.
- Reset asserted after 100 accepted vectors -> next cycle state IDLE, checked_count=0, busy=0. A following start plus 512 vectors completes normally.
- vec_valid pulses while in IDLE and DONE, and start pulsed mid-RUN -> no counter change and the sweep continues. start in DONE clears the counters and re-enters RUN.
- With CHECKER_ORDER_CHECK_EN: swap vectors #0 and #1, both with correct responses -> order_err=1, err_count=0, pass=0 at done.
